seg_scan_display: RTL



---
 rtl/seg_pkg.sv | 31 +++
 rtl/hex_to_seg7.sv | 18 +
 rtl/seg_scan_display.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the seven-segment scan driver:
//               FSM state encoding, "all off" patterns, hex glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Scan FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Active-low "nothing lit" patterns
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs, indexed by nibble value.
  // Packed literal lists the highest index (F) first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational 4-bit to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup into the shared glyph array
  assign seg_o = HEX_SEG[nibble_i];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Four-digit seven-segment scan driver. Steps one digit per
//               rising edge of an asynchronous scan strobe, inserts a
//               blanking gap between digits and latches the displayed value
//               once per frame.
//               Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//               (suppresses leading zero digits 3..1).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 16   // legal range 1..255
)(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

  // Strobe synchronizer and edge detector
  logic sync1_q, sync2_q, prev_q;
  logic tick;

  // FSM and datapath state
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        blank_entry;

  // Output flops
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  // Decoder path
  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg;
  logic        lz_blank;

  // Two-flop synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= scan_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ticks during BLANK (including its last cycle) are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick)          state_d = ST_BLANK;
      ST_BLANK: if (cnt_q == 8'd0) state_d = ST_DRIVE;
      ST_DRIVE: if (tick)          state_d = ST_BLANK;
      default:                     state_d = ST_IDLE;
    endcase
  end

  assign blank_entry = (state_d == ST_BLANK) && (state_q != ST_BLANK);

  // Blank counter, digit index and frame shadow next-state
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (blank_entry) begin
      cnt_d = CNT_LOAD;
      idx_d = idx_q + 2'd1;
      // Latch a fresh frame only when the scan wraps back to digit 0
      if (idx_d == 2'd0) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_mask;
      end
    end else if ((state_q == ST_BLANK) && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Datapath registers; idx resets to 3 so the first tick selects digit 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= 8'd0;
      idx_q        <= 2'd3;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
    end
  end

  // Select the shadow nibble for the current digit
  always_comb begin
    cur_nibble = shadow_val_q[3:0];
    case (idx_q)
      2'd0: cur_nibble = shadow_val_q[3:0];
      2'd1: cur_nibble = shadow_val_q[7:4];
      2'd2: cur_nibble = shadow_val_q[11:8];
      2'd3: cur_nibble = shadow_val_q[15:12];
      default: cur_nibble = shadow_val_q[3:0];
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Leading-zero suppression: a digit is dark when it and every digit to its
  // left is zero and its own decimal point is off. Digit 0 always shows.
  always_comb begin
    lz_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3: lz_blank = (shadow_val_q[15:12] == 4'h0) && !shadow_dp_q[3];
      2'd2: lz_blank = (shadow_val_q[15:8]  == 8'h00) && !shadow_dp_q[2];
      2'd1: lz_blank = (shadow_val_q[15:4]  == 12'h000) && !shadow_dp_q[1];
      default: lz_blank = 1'b0;
    endcase
`endif
  end

  // FSM output logic: next values for the output flops, derived from the next state
  always_comb begin
    an_d = AN_OFF;
    seg_d = SEG_OFF;
    dp_d = 1'b1;
    fs_d = (state_q == ST_BLANK) && (state_d == ST_DRIVE) && (idx_q == 2'd0);
    if ((state_d == ST_DRIVE) && !lz_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = cur_seg;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  // Output registers keep every output free of combinational input paths
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule : seg_scan_display
`default_nettype wire
